// File: rtl/caesar_pkg.sv
// Shared Caesar-cipher definitions: default widths and width-truncated shift helpers
// used by both the encryption and decryption stages.
package caesar_pkg;

    localparam int D_WIDTH_DEF   = 8;
    localparam int KEY_WIDTH_DEF = 16;

    function automatic logic [31:0] width_mask(input int unsigned width);
        logic [31:0] mask;
        if (width >= 32)
            mask = '1;
        else
            mask = (32'd1 << width) - 32'd1;
        return mask;
    endfunction

    // Only the low `width` bits of the key matter; the carry out is discarded.
    function automatic logic [31:0] caesar_shift_up(input logic [31:0] data,
                                                    input logic [31:0] key,
                                                    input int unsigned width);
        return (data + key) & width_mask(width);
    endfunction

    function automatic logic [31:0] caesar_shift_down(input logic [31:0] data,
                                                      input logic [31:0] key,
                                                      input int unsigned width);
        return (data - key) & width_mask(width);
    endfunction

endpackage

// File: rtl/caesar_encryption_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; read data is the combinational head entry.
module sync_fifo #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [D_WIDTH-1:0] pop_data,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_en;
    logic               pop_en;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_en && !pop_en)
                count <= count + CW'(1);
            else if (pop_en && !push_en)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/caesar_encryption.sv
// Caesar encryption stage: shifts each accepted character up by the key and queues it
// behind a valid/ready output register backed by a small FIFO.
module caesar_encryption
    import caesar_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 ready_i,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 overflow_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [D_WIDTH-1:0] enc;
    logic [D_WIDTH-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               accept;
    logic               load;
    logic               bypass;

    assign enc = D_WIDTH'(caesar_shift_up(32'(data_i), 32'(key), D_WIDTH));

    // busy depends only on the registered FIFO count, never on this cycle's inputs.
    assign busy   = (fifo_count == CW'(DEPTH));
    assign accept = valid_i && !busy;
    assign load   = !valid_o || ready_i;

    // The FIFO head always has priority over new input so ordering is preserved.
    assign fifo_pop  = load && !fifo_empty;
    assign bypass    = load && fifo_empty && accept;
    assign fifo_push = accept && !bypass && !fifo_full;

    sync_fifo #(
        .D_WIDTH(D_WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(enc),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (valid_i && busy)
                overflow_o <= 1'b1;
            if (load) begin
                if (!fifo_empty) begin
                    data_o  <= fifo_head;
                    valid_o <= 1'b1;
                end else if (accept) begin
                    data_o  <= enc;
                    valid_o <= 1'b1;
                end else begin
                    data_o  <= '0;
                    valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_caesar_encryption.sv
// Self-checking bench for caesar_encryption: directed scenarios plus a randomized
// round trip checked against a queue-based occupancy/ordering model.
module tb_caesar_encryption;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic [15:0] key = '0;
    logic        ready_i = 1'b0;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        overflow_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    caesar_encryption #(.D_WIDTH(8), .KEY_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .key       (key),
        .ready_i   (ready_i),
        .busy      (busy),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .overflow_o(overflow_o)
    );

    // Inputs are applied at a falling edge, held across one rising edge, and the
    // task returns at the next falling edge where outputs are settled.
    task automatic drive(input logic v, input logic [7:0] d, input logic [15:0] k, input logic r);
        valid_i = v; data_i = d; key = k; ready_i = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", data_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", overflow_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 16'h0000, 1'b1);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %0b want 0", valid_o); end
    endtask

    task automatic test_single();
        drive(1'b1, 8'h41, 16'd3, 1'b1);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", valid_o); end
        total++; if (data_o !== 8'h44) begin bad++; $display("FAIL single_data: got %0h want 44", data_o); end
        drive(1'b0, 8'h00, 16'd3, 1'b1);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_drain_valid: got %0b want 0", valid_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL single_drain_data: got %0h want 0", data_o); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 8'hFE, 16'd5, 1'b1);
        total++; if (data_o !== 8'h03 || valid_o !== 1'b1) begin bad++; $display("FAIL wrap_data: got %0h/%0b want 03/1", data_o, valid_o); end
        drive(1'b1, 8'h41, 16'h0103, 1'b1);
        total++; if (data_o !== 8'h44 || valid_o !== 1'b1) begin bad++; $display("FAIL key_trunc_data: got %0h/%0b want 44/1", data_o, valid_o); end
        drive(1'b0, 8'h00, 16'h0000, 1'b1);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL wrap_drain: got %0b want 0", valid_o); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h10 + i), 16'd1, 1'b0);
            total++; if (busy !== (i == 4)) begin bad++; $display("FAIL fill_busy_%0d: got %0b want %0b", i, busy, (i == 4)); end
        end
        total++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin bad++; $display("FAIL fill_head: got %0h/%0b want 11/1", data_o, valid_o); end
        drive(1'b1, 8'h15, 16'd1, 1'b0);
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL overflow_set: got %0b want 1", overflow_o); end
        total++; if (busy !== 1'b1 || data_o !== 8'h11) begin bad++; $display("FAIL overflow_hold: got busy %0b data %0h want 1/11", busy, data_o); end
        for (int i = 0; i < 5; i++) begin
            total++; if (valid_o !== 1'b1 || data_o !== 8'(8'h11 + i)) begin bad++; $display("FAIL drain_%0d: got %0h/%0b want %0h/1", i, data_o, valid_o, 8'(8'h11 + i)); end
            drive(1'b0, 8'h00, 16'd1, 1'b1);
            if (i == 0) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall: got %0b want 0", busy); end
            end
        end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0b want 0", valid_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %0b want 1", overflow_o); end
    endtask

    task automatic test_key_change();
        drive(1'b1, 8'h20, 16'd1, 1'b0);
        total++; if (data_o !== 8'h21 || valid_o !== 1'b1) begin bad++; $display("FAIL key1_data: got %0h/%0b want 21/1", data_o, valid_o); end
        drive(1'b1, 8'h20, 16'd2, 1'b0);
        total++; if (data_o !== 8'h21) begin bad++; $display("FAIL key_hold_data: got %0h want 21", data_o); end
        drive(1'b0, 8'h00, 16'd0, 1'b1);
        total++; if (data_o !== 8'h22 || valid_o !== 1'b1) begin bad++; $display("FAIL key2_data: got %0h/%0b want 22/1", data_o, valid_o); end
        drive(1'b0, 8'h00, 16'd0, 1'b1);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL key_drain: got %0b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h30, 16'd1, 1'b0);
        drive(1'b1, 8'h31, 16'd1, 1'b0);
        drive(1'b1, 8'h32, 16'd1, 1'b0);
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (data_o !== 8'h00 || valid_o !== 1'b0) begin bad++; $display("FAIL midrst_out: got %0h/%0b want 0/0", data_o, valid_o); end
        total++; if (busy !== 1'b0 || overflow_o !== 1'b0) begin bad++; $display("FAIL midrst_flags: got busy %0b ovf %0b want 0/0", busy, overflow_o); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 16'd0, 1'b1);
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst_idle_%0d: got %0b want 0", i, valid_o); end
        end
        drive(1'b1, 8'h55, 16'h0010, 1'b1);
        total++; if (data_o !== 8'h65 || valid_o !== 1'b1) begin bad++; $display("FAIL midrst_new: got %0h/%0b want 65/1", data_o, valid_o); end
        drive(1'b0, 8'h00, 16'd0, 1'b1);
    endtask

    task automatic test_round_trip();
        logic [7:0]  mq[$];
        logic [7:0]  orig[$];
        logic [15:0] rt_key;
        logic [7:0]  d, o, dec;
        logic        v, r;
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        rt_key = 16'($urandom);
        while ((sent < 256 || mq.size() > 0) && cyc < 5000) begin
            cyc++;
            total++; if (valid_o !== (mq.size() > 0)) begin bad++; $display("FAIL rt_valid cyc %0d: got %0b want %0b", cyc, valid_o, (mq.size() > 0)); end
            total++; if (busy !== (mq.size() == DEPTH + 1)) begin bad++; $display("FAIL rt_busy cyc %0d: got %0b want %0b", cyc, busy, (mq.size() == DEPTH + 1)); end
            if (mq.size() > 0) begin
                total++; if (data_o !== mq[0]) begin bad++; $display("FAIL rt_data cyc %0d: got %0h want %0h", cyc, data_o, mq[0]); end
            end
            r = ($urandom_range(0, 3) != 0);
            v = (sent < 256) && (mq.size() < DEPTH + 1) && ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (mq.size() > 0 && r) begin
                void'(mq.pop_front());
                o = orig.pop_front();
                dec = 8'(((int'(data_o) - int'(rt_key)) % 256 + 256) % 256);
                rcvd++;
                total++; if (dec !== o) begin bad++; $display("FAIL rt_decrypt #%0d: got %0h want %0h", rcvd, dec, o); end
            end
            if (v) begin
                mq.push_back(8'((int'(d) + int'(rt_key)) % 256));
                orig.push_back(d);
                sent++;
            end
            drive(v, d, rt_key, r);
        end
        total++; if (cyc >= 5000) begin bad++; $display("FAIL rt_timeout: got %0d cycles want < 5000", cyc); end
        total++; if (rcvd != 256) begin bad++; $display("FAIL rt_count: got %0d want 256", rcvd); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rt_overflow: got %0b want 0", overflow_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fill_overflow();
        test_key_change();
        test_reset_mid();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
